// File: rtl/hex_tx_fmt_if.sv
// Result/UART-side bundle for hex_tx_fmt: result handshake in, paced byte strobes out.
// The master modport belongs to whatever supplies results and baud ticks.
interface hex_tx_fmt_if #(
  parameter int DATA_W = 16
) ();
  logic              t_gen;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_err;
  logic              res_ready;
  logic [7:0]        u_out;
  logic              u_vaild;
  logic              busy;

  modport master (
    output t_gen, res_data, res_valid, res_err,
    input  res_ready, u_out, u_vaild, busy
  );

  modport slave (
    input  t_gen, res_data, res_valid, res_err,
    output res_ready, u_out, u_vaild, busy
  );
endinterface

// File: rtl/hex_tx_fmt.sv
// Formats one result word as uppercase ASCII hex followed by CR LF ("ERR" CR LF on error).
// Bytes are spaced by counting baud ticks, so the UART needs no busy feedback.
module hex_tx_fmt #(
  parameter int DATA_W      = 16,
  parameter int FRAME_TICKS = 11
) (
  input  logic        clk,
  input  logic        n_rst,
  hex_tx_fmt_if.slave bus
);
  localparam int DIGITS    = DATA_W / 4;
  localparam int MAX_BYTES = (DIGITS + 2 > 5) ? DIGITS + 2 : 5;
  localparam int IDX_W     = $clog2(MAX_BYTES + 1);
  localparam int TICK_W    = $clog2(FRAME_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  total_q, total_d;
  logic [IDX_W-1:0]  idx_inc;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [7:0]        u_out_q, u_out_d;
  logic              u_vaild_q, u_vaild_d;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] byte_at(input logic [DATA_W-1:0] data,
                                         input logic              err,
                                         input logic [IDX_W-1:0]  idx);
    logic [7:0] b;
    int         i;
    i = int'(idx);
    b = 8'h0A;
    if (err) begin
      if (i == 0)      b = 8'h45;
      else if (i <= 2) b = 8'h52;
      else if (i == 3) b = 8'h0D;
    end else if (i == DIGITS) begin
      b = 8'h0D;
    end else if (i < DIGITS) begin
      for (int k = 0; k < DIGITS; k++)
        if (i == k) b = hex_ascii(data[DATA_W-1-4*k -: 4]);
    end
    return b;
  endfunction

  assign idx_inc = idx_q + 1'b1;

  // u_out is loaded on the edge that enters EMIT so the byte and the strobe appear together.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d   = state_q;
    data_d    = data_q;
    err_d     = err_q;
    idx_d     = idx_q;
    total_d   = total_q;
    tick_d    = tick_q;
    u_out_d   = u_out_q;
    u_vaild_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.res_valid) begin
          data_d    = bus.res_data;
          err_d     = bus.res_err;
          idx_d     = '0;
          total_d   = bus.res_err ? IDX_W'(5) : IDX_W'(DIGITS + 2);
          u_out_d   = byte_at(bus.res_data, bus.res_err, '0);
          u_vaild_d = 1'b1;
          state_d   = S_EMIT;
        end
      end
      S_EMIT: begin
        tick_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.t_gen) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
            if (idx_inc < total_q) begin
              idx_d     = idx_inc;
              u_out_d   = byte_at(data_q, err_q, idx_inc);
              u_vaild_d = 1'b1;
              state_d   = S_EMIT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      total_q   <= '0;
      tick_q    <= '0;
      u_out_q   <= 8'h00;
      u_vaild_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      total_q   <= total_d;
      tick_q    <= tick_d;
      u_out_q   <= u_out_d;
      u_vaild_q <= u_vaild_d;
    end
  end

  assign bus.u_out     = u_out_q;
  assign bus.u_vaild   = u_vaild_q;
  assign bus.res_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_hex_tx_fmt.sv
// Directed bench for hex_tx_fmt: byte content, strobe pacing, drops, stalls and reset abort.
// A 16-bit and an 8-bit instance share clock, reset and baud ticks.
module tb_hex_tx_fmt;
  localparam int FT = 11;

  logic clk = 1'b0;
  logic n_rst;
  bit   tick_en = 1'b0;
  int   tick_ph = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] q_byte[$];
  int         q_gap[$];
  int         q_lag[$];
  int         q_end_gap[$];
  int         q_end_lag[$];
  logic [7:0] q8[$];

  logic [7:0] exp_norm[6] = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] exp_err[5]  = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
  logic [7:0] exp_zero[6] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
  logic [7:0] exp_c3[4]   = '{8'h43, 8'h33, 8'h0D, 8'h0A};

  hex_tx_fmt_if #(.DATA_W(16)) bus16 ();
  hex_tx_fmt_if #(.DATA_W(8))  bus8 ();

  hex_tx_fmt #(.DATA_W(16), .FRAME_TICKS(FT)) dut16 (.clk(clk), .n_rst(n_rst), .bus(bus16.slave));
  hex_tx_fmt #(.DATA_W(8),  .FRAME_TICKS(FT)) dut8  (.clk(clk), .n_rst(n_rst), .bus(bus8.slave));

  always #5 clk = ~clk;

  // Baud tick every 16 cycles, changed just after the rising edge.
  initial begin
    bus16.t_gen = 1'b0;
    bus8.t_gen  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick_ph++;
      bus16.t_gen = tick_en && (tick_ph % 16 == 0);
      bus8.t_gen  = bus16.t_gen;
    end
  end

  // Records each strobe with the ticks counted since the previous one and the cycles since the last tick.
  initial begin
    int since = 0;
    int last_tick = 0;
    bit prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!n_rst) begin
        since     = 0;
        prev_busy = 1'b0;
      end else begin
        if (bus16.u_vaild) begin
          q_byte.push_back(bus16.u_out);
          q_gap.push_back(since);
          q_lag.push_back(cyc - last_tick);
          since = 0;
        end else if (bus16.t_gen && bus16.busy) begin
          since++;
          last_tick = cyc;
        end
        if (prev_busy && !bus16.busy) begin
          q_end_gap.push_back(since);
          q_end_lag.push_back(cyc - last_tick);
        end
        prev_busy = bus16.busy;
        if (bus8.u_vaild) q8.push_back(bus8.u_out);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_q(input int n, input int budget);
    int k = 0;
    while (q_byte.size() < n && k < budget) begin
      step();
      k++;
    end
    check($sformatf("strobe_count_%0d", n), q_byte.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus16.busy && k < budget) begin
      step();
      k++;
    end
    check("idle_reached", bus16.busy, 1'b0);
  endtask

  task automatic clear_q();
    q_byte.delete();
    q_gap.delete();
    q_lag.delete();
    q_end_gap.delete();
    q_end_lag.delete();
  endtask

  task automatic request16(input logic [15:0] data, input logic err);
    check("ready_before_req", bus16.res_ready, 1'b1);
    bus16.res_data  = data;
    bus16.res_err   = err;
    bus16.res_valid = 1'b1;
    step();
    bus16.res_valid = 1'b0;
    check("first_strobe_latency", bus16.u_vaild, 1'b1);
    check("busy_with_first_strobe", bus16.busy, 1'b1);
  endtask

  task automatic check_pacing(input int n);
    for (int i = 1; i < n; i++) begin
      check($sformatf("gap_%0d", i), q_gap[i], FT);
      check($sformatf("lag_%0d", i), q_lag[i], 1);
    end
  endtask

  initial begin
    bus16.res_valid = 1'b0;
    bus16.res_data  = '0;
    bus16.res_err   = 1'b0;
    bus8.res_valid  = 1'b0;
    bus8.res_data   = '0;
    bus8.res_err    = 1'b0;
    n_rst           = 1'b0;
    tick_en         = 1'b1;
    repeat (3) step();
    check("rst_u_vaild", bus16.u_vaild, 1'b0);
    check("rst_u_out", bus16.u_out, 8'h00);
    check("rst_busy", bus16.busy, 1'b0);
    check("rst_ready", bus16.res_ready, 1'b1);
    n_rst = 1'b1;
    repeat (2) step();

    // Normal result with a dropped request while busy.
    clear_q();
    request16(16'h1A2F, 1'b0);
    check("first_byte", bus16.u_out, 8'h31);
    repeat (50) step();
    check("ready_low_while_busy", bus16.res_ready, 1'b0);
    bus16.res_data  = 16'h0000;
    bus16.res_valid = 1'b1;
    step();
    bus16.res_valid = 1'b0;
    wait_q(6, 3000);
    wait_idle(500);
    for (int i = 0; i < 6; i++) check($sformatf("norm_byte_%0d", i), q_byte[i], exp_norm[i]);
    check_pacing(6);
    check("norm_end_gap", q_end_gap[0], FT);
    check("norm_end_lag", q_end_lag[0], 1);

    // Error result captured in the very first IDLE cycle.
    clear_q();
    request16(16'hFFFF, 1'b1);
    check("err_first_byte", bus16.u_out, 8'h45);
    bus16.res_err = 1'b0;
    wait_q(5, 3000);
    wait_idle(500);
    for (int i = 0; i < 5; i++) check($sformatf("err_byte_%0d", i), q_byte[i], exp_err[i]);
    check_pacing(5);
    check("err_end_gap", q_end_gap[0], FT);
    repeat (400) step();
    check("no_extra_after_err", q_byte.size(), 5);

    // Stall ticks after the first strobe, then resume.
    clear_q();
    request16(16'h1A2F, 1'b0);
    tick_en = 1'b0;
    repeat (500) step();
    check("stall_no_strobe", q_byte.size(), 1);
    check("stall_busy", bus16.busy, 1'b1);
    tick_en = 1'b1;
    wait_q(2, 1000);
    check("resume_byte", q_byte[1], 8'h41);
    check_pacing(2);

    // Reset in mid-WAIT after the third strobe aborts the result.
    wait_q(3, 1000);
    repeat (20) step();
    n_rst = 1'b0;
    step();
    check("abort_u_vaild", bus16.u_vaild, 1'b0);
    check("abort_u_out", bus16.u_out, 8'h00);
    check("abort_busy", bus16.busy, 1'b0);
    check("abort_ready", bus16.res_ready, 1'b1);
    step();
    n_rst = 1'b1;
    step();
    check("post_rst_u_out", bus16.u_out, 8'h00);
    check("post_rst_ready", bus16.res_ready, 1'b1);
    repeat (400) step();
    check("abort_no_more", q_byte.size(), 3);

    // Leading zeros.
    clear_q();
    request16(16'h0000, 1'b0);
    wait_q(6, 3000);
    wait_idle(500);
    for (int i = 0; i < 6; i++) check($sformatf("zero_byte_%0d", i), q_byte[i], exp_zero[i]);
    check("zero_end_gap", q_end_gap[0], FT);

    // Narrow instance.
    check("w8_ready", bus8.res_ready, 1'b1);
    bus8.res_data  = 8'hC3;
    bus8.res_valid = 1'b1;
    step();
    bus8.res_valid = 1'b0;
    check("w8_first_strobe", bus8.u_vaild, 1'b1);
    begin
      int k = 0;
      while ((q8.size() < 4 || bus8.busy) && k < 3000) begin
        step();
        k++;
      end
    end
    check("w8_count", q8.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("w8_byte_%0d", i), q8[i], exp_c3[i]);
    check("w8_idle", bus8.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hex_tx_fmt.md
# hex_tx_fmt

Result-to-ASCII formatter sitting directly upstream of the UART transmitter. It accepts one calculator result word and emits it as uppercase ASCII hex digits, most significant first, followed by CR LF. Each byte goes out as `u_out` with a one-cycle `u_vaild` strobe. Bytes are paced by counting the transmitter's baud ticks (`t_gen`), so no busy feedback from the transmitter is needed. An error result is emitted as "ERR" CR LF instead of digits.

## Interface
- `DATA_W`, default 16: result width in bits. Must be a multiple of 4 and at least 4. Digit count is `DATA_W/4`.
- `FRAME_TICKS`, default 11: `t_gen` pulses to wait after each byte strobe before the next strobe. Covers 10 bit periods plus 1 guard. Must be ≥10.

- `clk`  in  1: system clock.
- `n_rst`  in  1: reset, asynchronous, active-low.
- `t_gen`  in  1: baud tick, one-cycle pulse per bit period, shared with the transmitter.
- `res_data`  in  `DATA_W`: result word.
- `res_valid`  in  1: result present. Accepted only when `res_ready`=1.
- `res_err`  in  1: error flag, sampled together with `res_data`.
- `res_ready`  out  1: high only in IDLE.
- `u_out`  out  8: byte to the transmitter. Held stable between strobes.
- `u_vaild`  out  1: one-cycle byte strobe to the transmitter.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- State machine: IDLE, EMIT, WAIT.
- **IDLE**
  - `res_ready`=1.
  - On `res_valid`=1, capture `res_data` and `res_err` into internal registers.
  - Set byte index to 0 and total count to `DATA_W/4`+2 (or 5 if `res_err`=1).
  - Go to EMIT.
- **EMIT** (exactly 1 cycle)
  - Register `u_out` with the byte for the current index; assert `u_vaild`.
  - Clear the tick counter; go to WAIT.
- **WAIT**
  - Increment the tick counter on each `t_gen`.
  - When the counter reaches `FRAME_TICKS`:
    - if bytes remain, increment the index and go to EMIT;
    - else go to IDLE.
- **Byte map, normal result**
  - Index `i` < `DATA_W/4`: nibble `res_data[DATA_W-1-4i -: 4]`.
  - Nibble 0–9 maps to 0x30–0x39; nibble 10–15 maps to 0x41–0x46.
  - Then 0x0D, then 0x0A.
- **Byte map, error result:** 0x45, 0x52, 0x52, 0x0D, 0x0A. `res_data` is ignored.
- **No buffering.** `res_valid` while `res_ready`=0 is dropped and has no effect on the output in progress.
- **Leading zeros are emitted.** 16'h0000 produces "0000".
- **Counter widths.** Tick counter is ≥ clog2(`FRAME_TICKS`+1) bits. Byte index is ≥ clog2(`DATA_W/4`+2) bits. Neither counter may wrap within a result.

## Timing
- **Reset values:** state IDLE, `u_out`=8'h00, `u_vaild`=0, `busy`=0, `res_ready`=1, counters 0.
- **Capture latency.** Result captured at clock edge N (IDLE, `res_valid`=1). First `u_vaild` is high in cycle N+1, and `busy` rises in the same cycle.
- **`u_vaild` is one cycle wide** and coincides with the new `u_out` value. `u_out` keeps its last value in IDLE.
- **Tick alignment.** A `t_gen` pulse in the same cycle as EMIT is not counted. Counting starts the cycle after the strobe.
- **Strobe spacing.** Consecutive strobes are separated by exactly `FRAME_TICKS` counted `t_gen` pulses plus 1 cycle.
- **Return to IDLE.** After the final LF, the cycle after the `FRAME_TICKS`th tick is IDLE: `res_ready`=1, `busy`=0.
- **Back-to-back results.** A new result can be captured in that first IDLE cycle.
- **Stalled ticks.** If `t_gen` stays low, the block stays in WAIT indefinitely and issues no further strobes.
- **Reset mid-operation.** `n_rst` low at any time aborts immediately and applies the reset values. No further `u_vaild` is issued for the aborted result.

## Test plan
- **Reset values:** assert `n_rst` low in mid-WAIT → `u_vaild`=0, `u_out`=8'h00, `busy`=0, `res_ready`=1 while low and after release.
- **Normal result:** `res_data`=16'h1A2F with `res_valid` pulse, `t_gen` every 16 cycles →
  - strobes carry 0x31, 0x41, 0x32, 0x46, 0x0D, 0x0A;
  - first strobe 1 cycle after capture;
  - 11 ticks counted between strobes;
  - `busy` drops after the 11th tick following LF.
- **Error result:** `res_err`=1, `res_data`=16'hFFFF → strobes carry 0x45, 0x52, 0x52, 0x0D, 0x0A, then IDLE.
- **Dropped request:** `res_valid` with 16'h0000 during an active 16'h1A2F output → `res_ready`=0 at that time, only "1A2F\r\n" is emitted, and no "0000" follows.
- **Stall, then resume:** after the first strobe, hold `t_gen` low for 500 cycles → no second strobe. Resume ticks → second strobe follows exactly 11 ticks later.
- **Reset abort, then parameter check:**
  - `n_rst` low for 2 cycles after the third strobe → no further strobes.
  - A new 16'h0000 request then yields 0x30, 0x30, 0x30, 0x30, 0x0D, 0x0A.
  - Repeat with `DATA_W`=8 and 8'hC3 → 0x43, 0x33, 0x0D, 0x0A.
